// File: rtl/spi_reg_responder.sv
// SPI register responder: command byte selects read/write and start address,
// followed by one write byte or an open-ended auto-incrementing read burst.
module spi_reg_responder #(
  parameter int                    NUM_REGS     = 16,
  parameter int                    IDLE_TIMEOUT = 64,
  parameter logic [NUM_REGS*8-1:0] REG_RESET    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  pico,
  output logic                  poci,
  input  logic [7:0]            status_in,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [7:0]            wr_addr,
  output logic                  busy
);

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              sclk_sync, pico_sync;
  logic                    sclk_d;
  logic                    sclk_rise, sclk_fall, pico_bit;
  logic [2:0]              bit_cnt;
  logic [6:0]              in_sr;
  logic [7:0]              in_byte;
  logic [6:0]              addr, addr_nxt;
  logic                    rd_loaded;
  logic [7:0]              rd_sr, rd_cur, rd_nxt;
  logic [CW-1:0]           idle_cnt;
  logic [NUM_REGS*8-1:8]   mem;
  logic                    last_bit, timeout;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign pico_bit  = pico_sync[1];
  assign in_byte   = {in_sr, pico_bit};
  assign last_bit  = sclk_rise && (bit_cnt == 3'd7);
  // An sclk rising edge in the same cycle always beats the timeout.
  assign timeout   = (state != IDLE) && !sclk_rise && (idle_cnt == CW'(IDLE_TIMEOUT - 1));
  assign addr_nxt  = (addr == 7'(NUM_REGS - 1)) ? 7'd0 : addr + 7'd1;
  assign poci      = rd_sr[7];
  assign busy      = (state != IDLE);
  assign reg_q     = {mem, status_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      pico_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      pico_sync <= {pico_sync[0], pico};
      sclk_d    <= sclk_sync[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sclk_rise) state_nxt = CMD;
      CMD:     if (last_bit)  state_nxt = in_sr[6] ? WDATA : RDATA;
      WDATA:   if (last_bit)  state_nxt = DONE;
      default: state_nxt = state;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_comb begin
    rd_cur = (addr == 7'd0) ? status_in : 8'h00;
    rd_nxt = (addr_nxt == 7'd0) ? status_in : 8'h00;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (addr == 7'(k))     rd_cur = mem[k*8 +: 8];
      if (addr_nxt == 7'(k)) rd_nxt = mem[k*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      in_sr     <= '0;
      addr      <= '0;
      rd_loaded <= 1'b0;
      rd_sr     <= '0;
      idle_cnt  <= '0;
      mem       <= REG_RESET[NUM_REGS*8-1:8];
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (sclk_rise || timeout) idle_cnt <= '0;
      else if (state != IDLE)   idle_cnt <= idle_cnt + CW'(1);

      if (timeout) begin
        bit_cnt <= '0;
        in_sr   <= '0;
        rd_sr   <= '0;
      end else begin
        if (sclk_rise && (state != DONE)) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (state != RDATA) in_sr <= in_byte[6:0];
        end
        if ((state == CMD) && last_bit) begin
          addr      <= in_byte[6:0];
          rd_loaded <= 1'b0;
        end
        if ((state == WDATA) && last_bit) begin
          wr_strobe <= 1'b1;
          wr_addr   <= {1'b0, addr};
          for (int k = 1; k < NUM_REGS; k++)
            if (addr == 7'(k)) mem[k*8 +: 8] <= in_byte;
        end
        // Byte boundary: the first fall loads the start address, later ones advance.
        if ((state == RDATA) && sclk_fall) begin
          if (bit_cnt == 3'd0) begin
            rd_loaded <= 1'b1;
            if (rd_loaded) begin
              addr  <= addr_nxt;
              rd_sr <= rd_nxt;
            end else begin
              rd_sr <= rd_cur;
            end
          end else begin
            rd_sr <= {rd_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_REGS, 16, number of 8-bit registers; address 0 is read-only status.
- IDLE_TIMEOUT, 64, number of clk cycles without an sclk rising edge that aborts a frame.
- REG_RESET, all 0x00, reset value of registers 1..NUM_REGS-1 (NUM_REGS*8 bits).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock.
- rst, in, 1, asynchronous, active-high reset.
- sclk, in, 1, SPI clock from the initiator; asynchronous to clk.
- pico, in, 1, serial data from the initiator, MSB first.
- poci, out, 1, serial data to the initiator, MSB first.
- status_in, in, 8, value returned on reads of address 0.
- reg_q, out, NUM_REGS*8, flat register contents; bits [8k+7:8k] hold register k, and bits [7:0] mirror status_in.
- wr_strobe, out, 1, one-cycle pulse when a register is written.
- wr_addr, out, 8, address of the last write; valid while wr_strobe is high.
- busy, out, 1, high whenever the state is not IDLE.

REQ-003 There SHALL be one clock domain (clk) and one asynchronous, active-high reset (rst).

Function
REQ-004 sclk and pico SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected on the synchronized value.
- Rising edge: sample pico.
- Falling edge: update poci.
REQ-005 The frame format SHALL be:
- Byte 0 = command: bit7 = 1 for write, 0 for read; bits[6:0] = start address.
- Write frame: byte 1 = data.
- Read frame: data bytes continue until the frame ends.
REQ-006 The state machine SHALL have states IDLE, CMD, WDATA, RDATA and DONE.
REQ-007 IDLE -> CMD SHALL occur on the first sclk rising edge; that edge captures command bit7.
REQ-008 CMD SHALL end after the 8th rising edge:
- bit7 = 1 -> WDATA.
- bit7 = 0 -> RDATA.
REQ-009 WDATA -> DONE SHALL occur after the 8th data rising edge.
- The register is updated on the clk cycle following that edge detection.
- wr_strobe is high for exactly that cycle, and wr_addr equals the address.
REQ-010 Writes to address 0 or to addresses >= NUM_REGS SHALL be ignored, but wr_strobe SHALL still pulse.
REQ-011 DONE SHALL ignore all further sclk edges and SHALL hold poci at 0 until the idle timeout returns the block to IDLE.
REQ-012 In RDATA, the read shift register SHALL be loaded on the falling edge that follows the 8th command rising edge.
- Data source: status_in for address 0, register[addr] for 1..NUM_REGS-1, 0x00 for addresses >= NUM_REGS.
- poci SHALL present the MSB immediately on load, then shift left one bit on each following falling edge.
REQ-013 After each 8 data bits, the address SHALL increment and the next byte SHALL be loaded on the same falling edge.
- The address wraps from NUM_REGS-1 to 0.
- Addresses from 7-bit wrap (127 -> 0) are also handled; out-of-range addresses read 0x00.
REQ-014 An idle counter SHALL reset on every sclk rising edge and count clk cycles in any non-IDLE state.
- Reaching IDLE_TIMEOUT forces IDLE, clears the bit counter and drives poci to 0.
- A partial command or a partial write byte SHALL be discarded and SHALL NOT pulse wr_strobe.
REQ-015 If an sclk rising edge and the timeout occur in the same cycle, the edge SHALL win and the counter SHALL clear.
REQ-016 reg_q SHALL update only through completed writes; status_in SHALL be sampled at byte-load time, not continuously during shifting.
REQ-017 The bit counter SHALL be 3 bits; the address register SHALL be 7 bits wide, zero-extended on wr_addr.

Reset
REQ-018 While rst is high, regardless of frame state:
- state = IDLE, poci = 0, wr_strobe = 0, wr_addr = 0x00, busy = 0.
- Registers 1..NUM_REGS-1 = REG_RESET.
- Synchronizers, shift registers and counters are cleared.
REQ-019 Reset asserted mid-frame SHALL abort the frame with no register update.
REQ-020 After rst deasserts, the first sclk rising edge SHALL be treated as bit7 of a new command.

Verification
REQ-021 Write: send frame 0x81, 0xF0 -> one wr_strobe pulse with wr_addr = 0x01; reg_q[15:8] = 0xF0; busy returns low IDLE_TIMEOUT cycles after the last edge.
REQ-022 Burst read: write reg2 = 0x03 and reg3 = 0x5A; set status_in = 0xA5; send 0x02 followed by 24 clocks -> poci bytes 0x03, 0x5A, 0x00.
REQ-023 Wrap: read command 0x0F followed by 16 clocks, with reg15 = 0x77 -> bytes 0x77, then status_in (address 0).
REQ-024 Abort: send 0x81 then only 4 data bits, then idle for more than IDLE_TIMEOUT cycles, then send frame 0x81, 0x3C -> no wr_strobe for the partial frame; reg1 = 0x3C after the second frame.
REQ-025 Protected/out-of-range: write 0x80,0xFF and 0xA0,0x11 (address 0x20) -> two wr_strobe pulses; reg_q unchanged; reading address 0x20 returns 0x00.
REQ-026 Reset mid-frame: assert rst after 12 bits of frame 0x85,0xAA -> reg5 stays 0x00 and all outputs are at reset values; the next full frame 0x85,0xAA writes reg5 = 0xAA.
